// File: rtl/bus_pkg.sv
// Shared types and constants for the memory-port bus arbiter.
// Optional bus locking is controlled by BUS_ARBITER_LOCK_EN (see bus_arbiter.sv).
package bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_XFER = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  localparam int unsigned BUS_TIMEOUT_DEFAULT = 15;
  // Wide enough for the largest supported TIMEOUT of 255.
  localparam int unsigned BUS_TCNT_W = 8;

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side request bus plus memory port of the arbiter.
// The lock vector exists only when BUS_ARBITER_LOCK_EN is defined.
interface bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        rd;
  logic [NUM_REQ-1:0]        wr;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        err;
  logic [DATA_W-1:0]         rdata;
  logic                      mem_rd;
  logic                      mem_wr;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      mem_ack;
`ifdef BUS_ARBITER_LOCK_EN
  logic [NUM_REQ-1:0]        lock;
`endif

  // Arbiter view.
  modport slave (
    input  req, rd, wr, addr, wdata, mem_rdata, mem_ack,
`ifdef BUS_ARBITER_LOCK_EN
    input  lock,
`endif
    output gnt, done, err, rdata, mem_rd, mem_wr, mem_addr, mem_wdata
  );

  // Requesting masters and memory view.
  modport master (
    output req, rd, wr, addr, wdata, mem_rdata, mem_ack,
`ifdef BUS_ARBITER_LOCK_EN
    output lock,
`endif
    input  gnt, done, err, rdata, mem_rd, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin search: first requester at or above ptr, wrapping.
module rr_picker #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic               any
);

  always_comb begin
    win = '0;
    any = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any && req[IDX_W'((32'(ptr) + k) % NUM_REQ)]) begin
        win[IDX_W'((32'(ptr) + k) % NUM_REQ)] = 1'b1;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ masters, with ack timeout.
// Define BUS_ARBITER_LOCK_EN to let a locked owner chain transfers without re-arbitration.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.slave bus
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TCNT_W = BUS_TCNT_W;

  arb_state_e         state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   ptr;
  logic [TCNT_W-1:0]  tcnt;

  logic [NUM_REQ-1:0] pick_win;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;

  logic               own_rd;
  logic               own_wr;
  logic [ADDR_W-1:0]  own_addr;
  logic [DATA_W-1:0]  own_wdata;
  logic               legal;
`ifdef BUS_ARBITER_LOCK_EN
  logic               own_req;
  logic               own_lock;
`endif

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req (bus.req),
    .ptr (ptr),
    .win (pick_win),
    .any (pick_any)
  );

  // One-hot winner to index.
  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_win[i]) pick_idx = IDX_W'(i);
    end
  end

  // Current owner's request fields.
  always_comb begin
    own_rd    = 1'b0;
    own_wr    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
`ifdef BUS_ARBITER_LOCK_EN
    own_req   = 1'b0;
    own_lock  = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner == IDX_W'(i)) begin
        own_rd    = bus.rd[i];
        own_wr    = bus.wr[i];
        own_addr  = bus.addr[i*ADDR_W +: ADDR_W];
        own_wdata = bus.wdata[i*DATA_W +: DATA_W];
`ifdef BUS_ARBITER_LOCK_EN
        own_req   = bus.req[i];
        own_lock  = bus.lock[i];
`endif
      end
    end
  end

  assign legal = own_rd ^ own_wr;

  // Memory port follows the owner only while transferring; illegal strobe pairs are masked.
  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state == ARB_XFER) begin
      bus.mem_rd    = own_rd & ~own_wr;
      bus.mem_wr    = own_wr & ~own_rd;
      bus.mem_addr  = own_addr;
      bus.mem_wdata = own_wdata;
    end
  end

  // Arbitration FSM with registered grant/completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner     <= '0;
      ptr       <= '0;
      tcnt      <= '0;
      bus.gnt   <= '0;
      bus.done  <= '0;
      bus.err   <= '0;
      bus.rdata <= '0;
    end else begin
      bus.done <= '0;
      bus.err  <= '0;
      case (state)
        ARB_IDLE: begin
          tcnt <= '0;
          if (pick_any) begin
            state   <= ARB_XFER;
            owner   <= pick_idx;
            bus.gnt <= pick_win;
            ptr     <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
          end
        end
        ARB_XFER: begin
          tcnt <= tcnt + TCNT_W'(1);
          if (!legal) begin
            state    <= ARB_DONE;
            bus.done <= bus.gnt;
            bus.err  <= bus.gnt;
          end else if (bus.mem_ack) begin
            // Ack beats a coincident timeout.
            state    <= ARB_DONE;
            bus.done <= bus.gnt;
            if (own_rd) bus.rdata <= bus.mem_rdata;
          end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
            state    <= ARB_DONE;
            bus.done <= bus.gnt;
            bus.err  <= bus.gnt;
          end
        end
        ARB_DONE: begin
          tcnt <= '0;
`ifdef BUS_ARBITER_LOCK_EN
          if (own_lock && own_req) begin
            state <= ARB_XFER;
          end else begin
            state   <= ARB_IDLE;
            bus.gnt <= '0;
          end
`else
          state   <= ARB_IDLE;
          bus.gnt <= '0;
`endif
        end
        default: begin
          state   <= ARB_IDLE;
          bus.gnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (2 masters, TIMEOUT 15).
// Lock scenario runs only when BUS_ARBITER_LOCK_EN is defined.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  bus_arbiter_if #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(32)) bus ();

  bus_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.req       = '0;
    bus.rd        = '0;
    bus.wr        = '0;
    bus.addr      = {16'h1234, 16'h0A00};
    bus.wdata     = {32'h1111_2222, 32'h3333_4444};
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
`ifdef BUS_ARBITER_LOCK_EN
    bus.lock      = '0;
`endif
    #1;
    total++; if (bus.gnt !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", bus.gnt); else passed++;
    total++; if (bus.done !== 2'b00) $display("FAIL reset_done: got %b expected 00", bus.done); else passed++;
    total++; if (bus.err !== 2'b00) $display("FAIL reset_err: got %b expected 00", bus.err); else passed++;
    total++; if (bus.rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", bus.rdata); else passed++;
    total++; if ({bus.mem_rd, bus.mem_wr} !== 2'b00) $display("FAIL reset_strobes: got %b expected 00", {bus.mem_rd, bus.mem_wr}); else passed++;
    total++; if (bus.mem_addr !== 16'h0) $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); else passed++;
    total++; if (bus.mem_wdata !== 32'h0) $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); else passed++;
    step();
    step();
    rst = 1'b0;
    step();
    total++; if (bus.gnt !== 2'b00) $display("FAIL idle_gnt: got %b expected 00", bus.gnt); else passed++;
  endtask

  task automatic test_single_read();
    bus.req       = 2'b10;
    bus.rd        = 2'b10;
    bus.wr        = 2'b00;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    step();  // cycle 1
    total++; if (bus.gnt !== 2'b10) $display("FAIL single_gnt: got %b expected 10", bus.gnt); else passed++;
    total++; if (bus.mem_rd !== 1'b1) $display("FAIL single_mem_rd: got %b expected 1", bus.mem_rd); else passed++;
    total++; if (bus.mem_addr !== 16'h1234) $display("FAIL single_mem_addr: got %h expected 1234", bus.mem_addr); else passed++;
    total++; if (bus.done !== 2'b00) $display("FAIL single_done_early: got %b expected 00", bus.done); else passed++;
    step();  // cycle 2
    total++; if (bus.done !== 2'b10) $display("FAIL single_done: got %b expected 10", bus.done); else passed++;
    total++; if (bus.err !== 2'b00) $display("FAIL single_err: got %b expected 00", bus.err); else passed++;
    total++; if (bus.rdata !== 32'hDEADBEEF) $display("FAIL single_rdata: got %h expected deadbeef", bus.rdata); else passed++;
    total++; if (bus.mem_rd !== 1'b0) $display("FAIL single_rd_in_done: got %b expected 0", bus.mem_rd); else passed++;
    bus.req     = 2'b00;
    bus.mem_ack = 1'b0;
    step();  // cycle 3
    total++; if (bus.gnt !== 2'b00 || bus.done !== 2'b00) $display("FAIL single_idle: got gnt %b done %b expected 00 00", bus.gnt, bus.done); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g [0:8];
    logic [1:0] exp_d [0:8];
    exp_g = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
    exp_d = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
    bus.req     = 2'b11;
    bus.rd      = 2'b00;
    bus.wr      = 2'b11;
    bus.mem_ack = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      total++; if (bus.gnt !== exp_g[c]) $display("FAIL b2b_gnt[%0d]: got %b expected %b", c + 1, bus.gnt, exp_g[c]); else passed++;
      total++; if (bus.done !== exp_d[c]) $display("FAIL b2b_done[%0d]: got %b expected %b", c + 1, bus.done, exp_d[c]); else passed++;
      if (c == 3) begin
        total++; if (bus.mem_wr !== 1'b1 || bus.mem_wdata !== 32'h1111_2222) $display("FAIL b2b_wdata: got wr %b data %h expected 1 11112222", bus.mem_wr, bus.mem_wdata); else passed++;
      end
    end
    bus.req     = 2'b00;
    bus.wr      = 2'b00;
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    int strobe_cycles = 0;
    bit got_done = 1'b0;
    bus.req     = 2'b01;
    bus.rd      = 2'b01;
    bus.wr      = 2'b00;
    bus.mem_ack = 1'b0;
    step();
    for (int i = 0; i < 40; i++) begin
      if (bus.done !== 2'b00) begin
        got_done = 1'b1;
        break;
      end
      if (bus.mem_rd === 1'b1) strobe_cycles++;
      step();
    end
    total++; if (!got_done) $display("FAIL timeout_wait: got no done within 40 cycles expected done"); else passed++;
    total++; if (strobe_cycles != 15) $display("FAIL timeout_strobes: got %0d expected 15", strobe_cycles); else passed++;
    total++; if (bus.done !== 2'b01 || bus.err !== 2'b01) $display("FAIL timeout_done_err: got done %b err %b expected 01 01", bus.done, bus.err); else passed++;
    total++; if (bus.mem_rd !== 1'b0) $display("FAIL timeout_rd_drop: got %b expected 0", bus.mem_rd); else passed++;
    total++; if (bus.rdata !== 32'hDEADBEEF) $display("FAIL timeout_rdata: got %h expected deadbeef", bus.rdata); else passed++;
    bus.req = 2'b00;
    step();
  endtask

  task automatic test_illegal();
    bus.req       = 2'b11;
    bus.rd        = 2'b11;
    bus.wr        = 2'b10;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    step();  // cycle 1: master 1 wins, ptr was 1
    total++; if (bus.gnt !== 2'b10) $display("FAIL illegal_gnt: got %b expected 10", bus.gnt); else passed++;
    total++; if ({bus.mem_rd, bus.mem_wr} !== 2'b00) $display("FAIL illegal_strobes: got %b expected 00", {bus.mem_rd, bus.mem_wr}); else passed++;
    step();  // cycle 2
    total++; if (bus.done !== 2'b10 || bus.err !== 2'b10) $display("FAIL illegal_done_err: got done %b err %b expected 10 10", bus.done, bus.err); else passed++;
    total++; if (bus.rdata !== 32'hDEADBEEF) $display("FAIL illegal_rdata: got %h expected deadbeef", bus.rdata); else passed++;
    bus.rd = 2'b01;
    step();  // cycle 3
    total++; if (bus.gnt !== 2'b00) $display("FAIL illegal_idle: got %b expected 00", bus.gnt); else passed++;
    step();  // cycle 4
    total++; if (bus.gnt !== 2'b01 || bus.mem_rd !== 1'b1) $display("FAIL illegal_next_owner: got gnt %b rd %b expected 01 1", bus.gnt, bus.mem_rd); else passed++;
    step();  // cycle 5
    total++; if (bus.done !== 2'b01 || bus.err !== 2'b00) $display("FAIL next_read_done: got done %b err %b expected 01 00", bus.done, bus.err); else passed++;
    total++; if (bus.rdata !== 32'hCAFEF00D) $display("FAIL next_read_rdata: got %h expected cafef00d", bus.rdata); else passed++;
    bus.req     = 2'b00;
    bus.rd      = 2'b00;
    bus.wr      = 2'b00;
    bus.mem_ack = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_xfer();
    bus.req     = 2'b10;
    bus.rd      = 2'b10;
    bus.wr      = 2'b00;
    bus.mem_ack = 1'b0;
    step();
    step();  // second XFER cycle
    total++; if (bus.mem_rd !== 1'b1) $display("FAIL rstmid_rd_before: got %b expected 1", bus.mem_rd); else passed++;
    rst = 1'b1;
    #1;
    total++; if (bus.mem_rd !== 1'b0 || bus.gnt !== 2'b00) $display("FAIL rstmid_drop: got rd %b gnt %b expected 0 00", bus.mem_rd, bus.gnt); else passed++;
    bus.req       = 2'b11;
    bus.rd        = 2'b11;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h55AA55AA;
    step();
    total++; if (bus.done !== 2'b00 || bus.rdata !== 32'h0) $display("FAIL rstmid_no_done: got done %b rdata %h expected 00 0", bus.done, bus.rdata); else passed++;
    rst = 1'b0;
    step();
    total++; if (bus.gnt !== 2'b01 || bus.done !== 2'b00) $display("FAIL rstmid_ptr0: got gnt %b done %b expected 01 00", bus.gnt, bus.done); else passed++;
    step();
    total++; if (bus.done !== 2'b01 || bus.rdata !== 32'h55AA55AA) $display("FAIL rstmid_read: got done %b rdata %h expected 01 55aa55aa", bus.done, bus.rdata); else passed++;
    bus.req     = 2'b00;
    bus.rd      = 2'b00;
    bus.mem_ack = 1'b0;
    step();
  endtask

`ifdef BUS_ARBITER_LOCK_EN
  task automatic test_lock();
    logic [1:0] exp_g [0:6];
    logic [1:0] exp_d [0:6];
    exp_g = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};
    exp_d = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
    bus.req     = 2'b11;
    bus.rd      = 2'b00;
    bus.wr      = 2'b11;
    bus.lock    = 2'b10;
    bus.mem_ack = 1'b1;
    for (int c = 0; c < 7; c++) begin
      step();
      total++; if (bus.gnt !== exp_g[c]) $display("FAIL lock_gnt[%0d]: got %b expected %b", c + 1, bus.gnt, exp_g[c]); else passed++;
      total++; if (bus.done !== exp_d[c]) $display("FAIL lock_done[%0d]: got %b expected %b", c + 1, bus.done, exp_d[c]); else passed++;
      if (c == 3) begin
        bus.req  = 2'b01;
        bus.lock = 2'b00;
      end
    end
    bus.req     = 2'b00;
    bus.wr      = 2'b00;
    bus.mem_ack = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_timeout();
    test_illegal();
    test_reset_mid_xfer();
`ifdef BUS_ARBITER_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
